// File: rtl/seg_scan_ctrl_if.sv
// Write bus from the CPU display store path into the seven-segment scan controller.
// The master drives one-cycle write strobes; the slave reports an uncommitted shadow write.
interface seg_scan_ctrl_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_blank;
    logic        pending;

    modport master (
        output wr_en,
        output wr_data,
        output wr_blank,
        input  pending
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  wr_blank,
        output pending
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Purpose: 4-digit seven-segment scan controller; writes are shadowed and committed only at a frame boundary.
// Latency: commit at the boundary edge, decode is combinational (new data shows in slot 0 of the next frame).
// Backpressure: none; every write strobe is accepted and the last one before a boundary wins.
// Optional macro SEG_DEGHOST_EN blanks the enables for DEGHOST_CYC cycles at the start of each slot.
module seg_scan_ctrl #(
    parameter int SCAN_DIV    = 100000,
    parameter int CNT_W       = 17,
    parameter int DEGHOST_CYC = 4
) (
    input  logic              sysclk,
    input  logic              reset,
    seg_scan_ctrl_if.slave    wr,
    output logic [3:0]        ENs,
    output logic [6:0]        BCDs,
    output logic              frame_tick
);

    if (SCAN_DIV < 2 || (longint'(1) << CNT_W) < longint'(SCAN_DIV) || DEGHOST_CYC < 0) begin : g_bad_params
        $error("seg_scan_ctrl: illegal SCAN_DIV/CNT_W/DEGHOST_CYC combination");
    end
`ifdef SEG_DEGHOST_EN
    if (DEGHOST_CYC >= SCAN_DIV) begin : g_bad_deghost
        $error("seg_scan_ctrl: DEGHOST_CYC must be below SCAN_DIV");
    end
`endif

    logic [CNT_W-1:0] div;
    logic [1:0]       slot;
    logic [15:0]      active_data;
    logic [3:0]       active_blank;
    logic [15:0]      shadow_data;
    logic [3:0]       shadow_blank;
    logic             pending_q;

    logic             last_div;
    logic             boundary;

    assign last_div = (div == CNT_W'(SCAN_DIV - 1));
    assign boundary = last_div && (slot == 2'd3);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            div          <= '0;
            slot         <= 2'd0;
            active_data  <= 16'h0000;
            active_blank <= 4'b0000;
            shadow_data  <= 16'h0000;
            shadow_blank <= 4'b0000;
            pending_q    <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= boundary;

            if (last_div) begin
                div  <= '0;
                slot <= slot + 2'd1;
            end else begin
                div  <= div + CNT_W'(1);
            end

            // A write landing on the boundary itself goes straight to the active copy.
            if (boundary) begin
                if (wr.wr_en) begin
                    active_data  <= wr.wr_data;
                    active_blank <= wr.wr_blank;
                end else if (pending_q) begin
                    active_data  <= shadow_data;
                    active_blank <= shadow_blank;
                end
                pending_q <= 1'b0;
            end else if (wr.wr_en) begin
                shadow_data  <= wr.wr_data;
                shadow_blank <= wr.wr_blank;
                pending_q    <= 1'b1;
            end
        end
    end

    assign wr.pending = pending_q;

    logic [3:0] nibble;
    logic [3:0] en_n;

    always_comb begin
        nibble = active_data[3:0];
        case (slot)
            2'd0: nibble = active_data[3:0];
            2'd1: nibble = active_data[7:4];
            2'd2: nibble = active_data[11:8];
            2'd3: nibble = active_data[15:12];
            default: nibble = active_data[3:0];
        endcase
    end

    always_comb begin
        BCDs = 7'b1000000;
        case (nibble)
            4'h0: BCDs = 7'b1000000;
            4'h1: BCDs = 7'b1111001;
            4'h2: BCDs = 7'b0100100;
            4'h3: BCDs = 7'b0110000;
            4'h4: BCDs = 7'b0011001;
            4'h5: BCDs = 7'b0010010;
            4'h6: BCDs = 7'b0000010;
            4'h7: BCDs = 7'b1111000;
            4'h8: BCDs = 7'b0000000;
            4'h9: BCDs = 7'b0010000;
            4'hA: BCDs = 7'b0001000;
            4'hB: BCDs = 7'b0000011;
            4'hC: BCDs = 7'b1000110;
            4'hD: BCDs = 7'b0100001;
            4'hE: BCDs = 7'b0000110;
            4'hF: BCDs = 7'b0001110;
            default: BCDs = 7'b1000000;
        endcase
    end

    // A blanked digit stays dark but still owns its full slot time.
    always_comb begin
        en_n = ~(4'b0001 << slot);
        if (active_blank[slot]) begin
            en_n = 4'b1111;
        end
`ifdef SEG_DEGHOST_EN
        if (div < CNT_W'(DEGHOST_CYC)) begin
            en_n = 4'b1111;
        end
`endif
    end

    assign ENs = en_n;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=4: table of committed frames plus hand sequences for
// boundary writes, double writes and mid-frame reset; expected frames go through a scoreboard queue.
module tb_seg_scan_ctrl;
    localparam int SCAN_DIV    = 4;
    localparam int CNT_W       = 2;
    localparam int DEGHOST_CYC = 1;
`ifdef SEG_DEGHOST_EN
    localparam bit DEGHOST = 1'b1;
`else
    localparam bit DEGHOST = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic [3:0] ENs;
    logic [6:0] BCDs;
    logic       frame_tick;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .CNT_W       (CNT_W),
        .DEGHOST_CYC (DEGHOST_CYC)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .wr         (bus.slave),
        .ENs        (ENs),
        .BCDs       (BCDs),
        .frame_tick (frame_tick)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [15:0]      data;
        logic [3:0]       blank;
        logic [3:0][6:0]  seg;   // [i] = segments shown in slot i
        logic [3:0][3:0]  en;    // [i] = ENs in slot i (without deghost)
    } vec_t;

    localparam logic [3:0][3:0] EN_NORM = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    vec_t tbl [4];
    vec_t sb_q [$];
    vec_t prev;
    vec_t v2;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_en(input logic [3:0] e, input int d);
        if (DEGHOST && d < DEGHOST_CYC) return 4'b1111;
        return e;
    endfunction

    task automatic drive_write(input logic [15:0] d, input logic [3:0] b);
        bus.wr_en    = 1'b1;
        bus.wr_data  = d;
        bus.wr_blank = b;
    endtask

    // Cycle c=1 is the first cycle after reset was sampled high.
    task automatic check_post_reset(input int n);
        for (int c = 1; c <= n; c++) begin
            check("rst_ens",   16'(ENs), 16'(exp_en(EN_NORM[((c-1)/4)%4], (c-1)%4)));
            check("rst_bcds",  16'(BCDs), 16'(7'b1000000));
            check("rst_pend",  16'(bus.pending), 16'(1'b0));
            check("rst_ftick", 16'(frame_tick), 16'((c == 17) || (c == 33)));
            if (c < n) tick();
        end
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (frame_tick) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame: frame_tick got 0 within 40 cycles, expected 1");
        end
    endtask

    // Entered in the first cycle of slot 0; leaves at the first cycle of the next frame.
    task automatic check_frame();
        vec_t v;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue size got 0, expected >0");
            return;
        end
        v = sb_q.pop_front();
        for (int k = 0; k < 16; k++) begin
            check("frm_ens",   16'(ENs), 16'(exp_en(v.en[k/4], k%4)));
            check("frm_bcds",  16'(BCDs), 16'(v.seg[k/4]));
            check("frm_pend",  16'(bus.pending), 16'(1'b0));
            check("frm_ftick", 16'(frame_tick), 16'(k == 0));
            tick();
        end
        prev = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time got 100000, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].data = 16'h1A8F; tbl[0].blank = 4'b0000;
        tbl[0].seg  = {7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110};
        tbl[0].en   = EN_NORM;
        tbl[1].data = 16'h3456; tbl[1].blank = 4'b0100;
        tbl[1].seg  = {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
        tbl[1].en   = {4'b0111, 4'b1111, 4'b1101, 4'b1110};
        tbl[2].data = 16'hEDCB; tbl[2].blank = 4'b1001;
        tbl[2].seg  = {7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011};
        tbl[2].en   = {4'b1111, 4'b1011, 4'b1101, 4'b1111};
        tbl[3].data = 16'h0789; tbl[3].blank = 4'b0000;
        tbl[3].seg  = {7'b1000000, 7'b1111000, 7'b0000000, 7'b0010000};
        tbl[3].en   = EN_NORM;

        prev.data  = 16'h0000;
        prev.blank = 4'b0000;
        prev.seg   = {4{7'b1000000}};
        prev.en    = EN_NORM;

        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 16'h0000;
        bus.wr_blank = 4'b0000;
        repeat (3) tick();
        reset = 1'b0;
        check_post_reset(34);
        wait_frame();

        // Single writes in slot 1, committed at the next boundary.
        for (int i = 0; i < 4; i++) begin
            repeat (5) tick();
            drive_write(tbl[i].data, tbl[i].blank);
            sb_q.push_back(tbl[i]);
            tick();
            bus.wr_en = 1'b0;
            check("wr_pend_set", 16'(bus.pending), 16'(1'b1));
            check("wr_old_shown", 16'(BCDs), 16'(prev.seg[1]));
            repeat (9) tick();
            check("wr_pend_hold", 16'(bus.pending), 16'(1'b1));
            tick();
            check_frame();
        end

        // Two writes in one frame: the last one wins.
        repeat (2) tick();
        drive_write(16'h1111, 4'b0000);
        tick();
        drive_write(16'h2222, 4'b0000);
        v2.data = 16'h2222; v2.blank = 4'b0000;
        v2.seg  = {4{7'b0100100}};
        v2.en   = EN_NORM;
        sb_q.push_back(v2);
        tick();
        bus.wr_en = 1'b0;
        check("dbl_pend", 16'(bus.pending), 16'(1'b1));
        repeat (11) tick();
        tick();
        check_frame();

        // Write exactly in the boundary cycle bypasses the shadow.
        repeat (15) tick();
        check("bnd_pend_pre", 16'(bus.pending), 16'(1'b0));
        drive_write(16'h00F0, 4'b0000);
        v2.data = 16'h00F0; v2.blank = 4'b0000;
        v2.seg  = {7'b1000000, 7'b1000000, 7'b0001110, 7'b1000000};
        v2.en   = EN_NORM;
        sb_q.push_back(v2);
        tick();
        bus.wr_en = 1'b0;
        check_frame();

        // Pending write discarded by a mid-frame reset that also collides with wr_en.
        repeat (2) tick();
        drive_write(16'hFFFF, 4'b0000);
        tick();
        bus.wr_en = 1'b0;
        check("rst_pend_pre", 16'(bus.pending), 16'(1'b1));
        repeat (5) tick();
        reset = 1'b1;
        drive_write(16'hFFFF, 4'b0000);
        tick();
        reset = 1'b0;
        bus.wr_en = 1'b0;
        check_post_reset(20);

        check("sb_empty", 16'(sb_q.size()), 16'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed controller for the CPU's 4-digit seven-segment display (ENs/BCDs outputs).
- Accepts one-cycle write strobes from the CPU's display store path.
- Holds each write in a shadow register and commits it only at a frame boundary, so a refresh never shows a mix of old and new digits.
- Scans the four digits on sysclk, one digit per slot of SCAN_DIV cycles.

Parameters:
SCAN_DIV, 100000, sysclk cycles per digit slot; legal range ≥ 2.
CNT_W, 17, divider counter width; must satisfy 2^CNT_W ≥ SCAN_DIV.
DEGHOST_CYC, 4, blanking cycles at slot start; used only with SEG_DEGHOST_EN; must be < SCAN_DIV.

Ports:
sysclk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  one-cycle write strobe
wr_data  input  16  four hex nibbles; [3:0]=digit0 … [15:12]=digit3
wr_blank  input  4  per-digit blank mask; 1 = digit dark
ENs  output  4  active-low digit enables, one-hot low; bit i = digit i
BCDs  output  7  active-low segments {g,f,e,d,c,b,a}
pending  output  1  shadow holds an uncommitted write
frame_tick  output  1  one-cycle pulse when slot wraps 3→0

Behaviour:
- Clock and reset: single clock sysclk; reset is synchronous and active-high, sampled on the sysclk rising edge.
- Reset values: div=0, slot=0, active_data=16'h0000, active_blank=4'b0000, shadow cleared, pending=0, frame_tick=0.
- Outputs after reset (without SEG_DEGHOST_EN): ENs=4'b1110, BCDs=7'b1000000.
- Divider: div counts 0..SCAN_DIV-1.
  - At div==SCAN_DIV-1: div←0 and slot←slot+1 mod 4.
  - Otherwise div←div+1.
- Frame boundary cycle: the cycle with div==SCAN_DIV-1 and slot==3.
  - frame_tick is registered and is high exactly for the first cycle of the new slot 0.
- Write handling:
  - Non-boundary cycle with wr_en=1: shadow←{wr_data,wr_blank}, pending←1.
  - A later write before commit overwrites the shadow; last write wins and no error is flagged.
- Commit at the boundary edge:
  - If wr_en=1 in the boundary cycle: active←{wr_data,wr_blank} directly, pending←0. The write bypasses the shadow and takes precedence over any older shadow content.
  - Else if pending=1: active←shadow, pending←0.
  - Else: active is unchanged.
- Output decode: combinational from registered state (slot, active_*, div). Display latency after a commit is 0 cycles; new data is visible in slot 0 of the next frame.
  - ENs = ~(4'b0001<<slot), forced to 4'b1111 when active_blank[slot]=1. A blanked slot still consumes its full slot time.
  - BCDs = hex decode of nibble active_data[4*slot+:4].
  - Segment values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-operation: all state returns to reset values on the next edge. Any pending write is discarded.
- Reset has priority over wr_en in the same cycle.

Optional Feature:
Macro: SEG_DEGHOST_EN.
- Defined: while div < DEGHOST_CYC, ENs=4'b1111; BCDs keeps decoding normally. This suppresses ghosting on the digit transition. After reset, ENs=4'b1111 for DEGHOST_CYC cycles, then 4'b1110.
- Undefined: the digit enable is asserted for the whole slot; DEGHOST_CYC is ignored.

Test Plan:
1. Assert reset 3 cycles, then release, SCAN_DIV=4 → ENs=1110, BCDs=1000000, pending=0, frame_tick=0. ENs steps 1110→1101→1011→0111→1110 every 4 cycles. frame_tick is high once, in the 17th cycle after release, and every 16 cycles thereafter.
2. wr_en with wr_data=16'h1A8F, wr_blank=0 during slot 1 → pending=1 and the display still shows 0 for the rest of the frame. After the boundary: slot0 BCDs=0001110, slot1 0000000, slot2 0001000, slot3 1111001; pending=0.
3. Two writes in one frame (16'h1111 then 16'h2222) → after the boundary, all slots show 0100100.
4. wr_en with 16'h00F0 exactly in the boundary cycle → pending never rises. The next slot 0 shows 1000000 and slot 1 shows 0001110.
5. Commit wr_blank=4'b0100 → ENs=1111 for the 4 cycles of slot 2; other slots are unaffected.
6. Write 16'hFFFF, then assert reset before the boundary → pending=0, slot=0, and the display shows 0 with no F ever displayed. With SEG_DEGHOST_EN and DEGHOST_CYC=1, the first cycle of each slot has ENs=1111.
